// File: rtl/reg_pkg.sv
// Shared register-file definitions used by the dump streamer and the register file.
// Optional checksum beat is enabled elsewhere with REG_DUMP_CHECKSUM_EN.
package reg_pkg;

  localparam int NUM_REGS = 16;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 4;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // CSUM is always encoded so the state width is build-independent.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    CSUM = 3'd3,
    FIN  = 3'd4
  } dump_state_e;

endpackage

// File: rtl/reg_dump_streamer.sv
// Walks the register file through one read port and streams each byte out over valid/ready.
// Define REG_DUMP_CHECKSUM_EN to append a mod-2**DATA_W checksum beat after the last register.
module reg_dump_streamer #(
  parameter int NUM_REGS = reg_pkg::NUM_REGS,
  parameter int DATA_W   = reg_pkg::DATA_W,
  parameter int ADDR_W   = reg_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last
);

  import reg_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state_r;
  logic [ADDR_W-1:0] idx_r;
  logic              xfer_s;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_r;
`endif

  assign rd_addr = idx_r;
  assign xfer_s  = out_valid && out_ready;

  // Dump sequencer: every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      idx_r     <= {ADDR_W{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= {DATA_W{1'b0}};
      out_index <= {ADDR_W{1'b0}};
      out_last  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_r    <= {DATA_W{1'b0}};
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (start && !done) begin
            idx_r   <= {ADDR_W{1'b0}};
            busy    <= 1'b1;
            state_r <= LOAD;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_r  <= {DATA_W{1'b0}};
`endif
          end
        end
        LOAD: begin
          out_data  <= rd_data;
          out_index <= idx_r;
          out_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          out_last  <= 1'b0;
`else
          out_last  <= (idx_r == LAST_IDX);
`endif
          state_r   <= SEND;
        end
        SEND: begin
          if (xfer_s) begin
            out_valid <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_r    <= csum_r + out_data;
`endif
            if (idx_r == LAST_IDX) begin
              out_last <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
              state_r  <= CSUM;
`else
              state_r  <= FIN;
`endif
            end else begin
              idx_r   <= idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
              state_r <= LOAD;
            end
          end
        end
        CSUM: begin
`ifdef REG_DUMP_CHECKSUM_EN
          // First cycle presents the checksum beat, then wait for its handshake.
          if (!out_valid) begin
            out_data  <= csum_r;
            out_index <= {ADDR_W{1'b0}};
            out_last  <= 1'b1;
            out_valid <= 1'b1;
          end else if (xfer_s) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state_r   <= FIN;
          end
`else
          state_r <= IDLE;
`endif
        end
        FIN: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Self-checking bench for reg_dump_streamer: a register-file model, a beat-queue scoreboard and directed scenarios.
module tb_reg_dump_streamer;
  import reg_pkg::*;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam int BEATS = NUM_REGS + 1;
  localparam int TOTAL = 2 * NUM_REGS + 4;
`else
  localparam int BEATS = NUM_REGS;
  localparam int TOTAL = 2 * NUM_REGS + 2;
`endif

  typedef struct {
    reg_data_t data;
    reg_addr_t index;
    logic      last;
  } beat_t;

  logic      clk = 1'b0;
  logic      reset, start, out_ready;
  logic      busy, done, out_valid, out_last;
  reg_addr_t rd_addr, out_index;
  reg_data_t rd_data, out_data;
  reg_data_t regs [NUM_REGS];

  assign rd_data = regs[rd_addr];

  reg_dump_streamer dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Scoreboard state
  bit        m_acc = 1'b0;
  int        m_start = 0;
  int        m_end = 0;
  beat_t     exp_q [$];
  reg_data_t got_data [$];
  bit        prev_stall = 1'b0;
  bit        chk_zero = 1'b0;
  reg_data_t p_data;
  reg_addr_t p_index;
  logic      p_last;
  int        done_count = 0;
  int        last_done_cyc = 0;

  always @(negedge clk) begin
    bit    in_dump;
    beat_t e;
    reg_data_t sum;
    in_dump = m_acc && (cyc > m_start) && (cyc < m_end);
    if (chk_zero) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk_zero = 1'b0;
    end else if (!reset) begin
      chk("busy", 32'(busy), 32'(in_dump));
      chk("done", 32'(done), 32'(m_acc && cyc == m_end));
    end
    if (done === 1'b1) begin
      done_count++;
      last_done_cyc = cyc;
      chk("beats_left_at_done", 32'(exp_q.size()), 32'd0);
    end
    if (prev_stall) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(p_data));
      chk("stall_index", 32'(out_index), 32'(p_index));
      chk("stall_last", 32'(out_last), 32'(p_last));
    end
    if (out_valid === 1'b1 && !reset) begin
      if (!in_dump) begin
        chk("valid_outside_dump", 32'(out_valid), 32'd0);
      end else if (out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 32'(out_data), 32'(e.data));
          chk("beat_index", 32'(out_index), 32'(e.index));
          chk("beat_last", 32'(out_last), 32'(e.last));
          got_data.push_back(out_data);
        end
      end else begin
        m_end++;
      end
    end
    prev_stall = (out_valid === 1'b1) && !out_ready && !reset;
    p_data = out_data;
    p_index = out_index;
    p_last = out_last;
    if (reset) begin
      m_acc = 1'b0;
      exp_q.delete();
      prev_stall = 1'b0;
      chk_zero = 1'b1;
    end else if (start && !(m_acc && cyc <= m_end)) begin
      m_acc = 1'b1;
      m_start = cyc;
      m_end = cyc + TOTAL;
      got_data.delete();
      sum = 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
        e.data = regs[i];
        e.index = reg_addr_t'(i);
`ifdef REG_DUMP_CHECKSUM_EN
        e.last = 1'b0;
`else
        e.last = (i == NUM_REGS - 1);
`endif
        sum = sum + regs[i];
        exp_q.push_back(e);
      end
`ifdef REG_DUMP_CHECKSUM_EN
      e.data = sum;
      e.index = 4'd0;
      e.last = 1'b1;
      exp_q.push_back(e);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_beat(input int idx);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (out_valid && out_index == reg_addr_t'(idx)) seen = 1'b1;
      else tick();
    end
    chk("wait_beat_timeout", 32'(seen), 32'd1);
  endtask

  task automatic wait_done(input int dc0);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (done_count > dc0) seen = 1'b1;
    end
    chk("wait_done_timeout", 32'(seen), 32'd1);
    tick();
  endtask

  initial begin
    int s, s2, dc0;
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, s2, dc0;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 8'h10 + 8'(i);
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_rd_addr", 32'(rd_addr), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data", 32'(out_data), 32'd0);
    chk("reset_index", 32'(out_index), 32'd0);
    chk("reset_last", 32'(out_last), 32'd0);
    tick();

    // Basic dump
    dc0 = done_count;
    pulse_start(s);
    wait_done(dc0);
    chk("basic_latency", 32'(last_done_cyc - s), 32'(TOTAL));
    chk("basic_latency_literal", 32'(last_done_cyc - s), 32'(NUM_REGS == 16 ? 34 + (BEATS - 16) * 2 : TOTAL));
    chk("basic_count", 32'(got_data.size()), 32'(BEATS));
    if (got_data.size() >= 16) begin
      chk("basic_first", 32'(got_data[0]), 32'h10);
      chk("basic_last_byte", 32'(got_data[15]), 32'h1F);
    end
`ifdef REG_DUMP_CHECKSUM_EN
    if (got_data.size() >= 17) chk("csum_byte", 32'(got_data[16]), 32'h78);
`endif

    // Backpressure on beat 3 with a register write during the stall
    dc0 = done_count;
    pulse_start(s);
    wait_beat(3);
    out_ready = 1'b0;
    regs[3] = 8'hEE;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_data", 32'(out_data), 32'h13);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    wait_done(dc0);
    chk("bp_count", 32'(got_data.size()), 32'(BEATS));
    if (got_data.size() >= 5) begin
      chk("bp_beat3", 32'(got_data[3]), 32'h13);
      chk("bp_beat4", 32'(got_data[4]), 32'h14);
    end
    regs[3] = 8'h13;

    // Start while busy is ignored
    dc0 = done_count;
    pulse_start(s);
    wait_beat(2);
    pulse_start(s2);
    wait_beat(9);
    pulse_start(s2);
    wait_done(dc0);
    repeat (4) tick();
    chk("busy_start_dones", 32'(done_count - dc0), 32'd1);
    chk("busy_start_count", 32'(got_data.size()), 32'(BEATS));
    chk("busy_start_idle", 32'(busy), 32'd0);

    // Reset mid-dump after beat 7 is accepted
    pulse_start(s);
    wait_beat(7);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    tick();
    dc0 = done_count;
    pulse_start(s);
    wait_done(dc0);
    chk("after_rst_count", 32'(got_data.size()), 32'(BEATS));
    if (got_data.size() >= 1) chk("after_rst_first", 32'(got_data[0]), 32'h10);

    // Back-to-back: start on done is dropped, start the next cycle is taken
    dc0 = done_count;
    pulse_start(s);
    for (int k = 0; k < 100 && !done; k++) tick();
    start = 1'b1;
    tick();
    s2 = cyc;
    tick();
    start = 1'b0;
    wait_done(dc0 + 1);
    chk("b2b_dones", 32'(done_count - dc0), 32'd2);
    chk("b2b_latency", 32'(last_done_cyc - s2), 32'(TOTAL));
    chk("b2b_count", 32'(got_data.size()), 32'(BEATS));

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_dump_streamer.md
Name: reg_dump_streamer

Overview:
- Debug/readout initiator for the 16-entry, 8-bit register file.
- On a start pulse it drives one register-file read port through addresses 0..NUM_REGS-1.
- Each value is captured and streamed out as one byte per beat over a valid/ready handshake with backpressure.
- Sits beside the core datapath, sharing one read port (mux owned by the top level), and feeds the testbench/debug output path.

Parameters:
- NUM_REGS, 16, number of registers to dump; must be a power of two no larger than 2**ADDR_W.
- DATA_W, 8, register and stream data width.
- ADDR_W, 4, register address width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a dump; sampled only in IDLE
- busy  output  1  high from the cycle after an accepted start until the cycle done is asserted
- done  output  1  one-cycle pulse after the final beat is accepted
- rd_addr  output  ADDR_W  read address to the register-file read port
- rd_data  input  DATA_W  combinational read data for rd_addr
- out_valid  output  1  stream beat valid
- out_ready  input  1  downstream ready
- out_data  output  DATA_W  stream byte
- out_index  output  ADDR_W  register index of the current beat
- out_last  output  1  marks the final beat of a dump

Behaviour:
- Reset values: busy=0, done=0, rd_addr=0, out_valid=0, out_data=0, out_index=0, out_last=0; state=IDLE; index counter=0.
- Reset mid-dump aborts immediately. No partial beat survives, done is not pulsed, and the next dump restarts at register 0.
- All outputs are registered except rd_addr, which equals the index counter (registered).
- IDLE:
  - start=1: idx<=0, busy<=1, go to LOAD.
  - start=0: hold.
- LOAD (one cycle):
  - out_data<=rd_data, out_index<=idx, out_valid<=1.
  - out_last<=(idx==NUM_REGS-1).
  - Go to SEND.
- SEND:
  - Beat transfers when out_valid && out_ready.
  - While out_ready=0: out_data, out_index and out_last hold stable, and out_valid stays 1 (AXI-style rule).
  - Later register-file writes do not affect a captured beat.
  - On transfer with idx<NUM_REGS-1: out_valid<=0, idx<=idx+1, go to LOAD.
  - On transfer with idx==NUM_REGS-1: out_valid<=0, out_last<=0, go to FIN.
- FIN (one cycle): done<=1, busy<=0, go to IDLE. done is a single-cycle pulse.
- Throughput: at most one beat per 2 cycles. A full dump with out_ready tied high takes 1 (IDLE→LOAD) + 2*NUM_REGS + 1 cycles from start to done, i.e. 34 cycles for 16 registers.
- Start handling:
  - start while not IDLE is ignored, with no queuing.
  - start in the same cycle as done is ignored; a new start is accepted from the next cycle.
- Index arithmetic is unsigned ADDR_W and never wraps during a dump, because termination is on NUM_REGS-1.
- The register file is not frozen. Each byte reflects register contents in that register's LOAD cycle.

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN.
- Defined:
  - An extra CSUM beat follows register NUM_REGS-1.
  - Its out_data is the mod-2**DATA_W sum of all NUM_REGS bytes sent; out_index=0.
  - out_last is asserted on the CSUM beat only, not on register NUM_REGS-1.
  - The accumulator clears on an accepted start and on reset.
  - Done is delayed by the 2 cycles of the extra beat.
- Undefined: no checksum logic or state; out_last is on register NUM_REGS-1.

Decomposition:
- Shared package reg_pkg holds:
  - NUM_REGS, DATA_W, ADDR_W defaults, shared with the register file.
  - typedef reg_addr_t (logic[ADDR_W-1:0]) and reg_data_t (logic[DATA_W-1:0]).
  - State enum dump_state_e {IDLE, LOAD, SEND, CSUM, FIN}; CSUM is encoded always and used only under the macro.
- Single module, no sub-module. The checksum accumulator is an inline `ifdef block.

Test Plan:
- Basic dump: registers preloaded with reg[i]=8'h10+i, out_ready=1, start pulse →
  - 16 beats with data 8'h10..8'h1F and out_index 0..15;
  - out_last only on index 15;
  - done exactly 34 cycles after start; busy deasserts in the same cycle.
- Backpressure: hold out_ready=0 for 5 cycles on the beat with index 3 while writing reg[3]=8'hEE during the stall →
  - out_data stays 8'h13 and out_valid stays 1 throughout;
  - the stream completes in order with no drop or duplicate.
- Start while busy: pulse start at beats 2 and 9 → ignored; exactly 16 beats and one done pulse.
- Reset mid-dump: assert reset after beat 7 is accepted →
  - next cycle out_valid=0, busy=0, done=0;
  - a new start yields indices 0..15 from 0.
- Back-to-back: start in the cycle after done → second dump begins normally; a start coincident with done is ignored.
- Checksum (REG_DUMP_CHECKSUM_EN), reg[i]=8'h10+i →
  - 17th beat data 8'h78 (sum 0x178 mod 256) with out_last=1;
  - beat index 15 has out_last=0.
